// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, redirect,
// multi-cycle mul/div occupancy of Execute and data-memory wait states with timeout.
module pipe_hazard_ctrl #(
    parameter int MDIV_LAT    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           D_ra,
    input  logic [4:0]           D_rb,
    input  logic [4:0]           E_rd,
    input  logic                 E_RegWrite,
    input  logic [1:0]           E_result_src,
    input  logic                 E_redirect,
    input  logic                 E_mdiv,
    input  logic                 M_mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 F_D_en,
    output logic                 D_E_en,
    output logic                 E_M_en,
    output logic                 F_D_flush,
    output logic                 CTRL_Flush,
    output logic                 E_M_flush,
    output logic                 M_W_flush,
    output logic                 mdiv_done,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam int MCW = $clog2(MDIV_LAT);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {EX_RUN, EX_MDIV} ex_state_t;
    typedef enum logic {M_IDLE, M_WAIT} mem_state_t;

    ex_state_t  ex_state;
    mem_state_t mem_state;
    logic [MCW-1:0] mcnt;
    logic [WCW-1:0] wcnt;

    logic timeout_now;
    logic mem_stall;
    logic mdiv_freeze;
    logic mdiv_release;
    logic lu;

    assign timeout_now  = (mem_state == M_WAIT) && (wcnt == WCW'(MEM_TIMEOUT));
    assign mem_stall    = M_mem_req && !mem_ready && !timeout_now;
    assign mdiv_freeze  = ((ex_state == EX_RUN) && E_mdiv) ||
                          ((ex_state == EX_MDIV) && (mcnt != '0));
    assign mdiv_release = (ex_state == EX_MDIV) && (mcnt == '0);
    assign lu = E_RegWrite && (E_result_src == 2'b01) && (E_rd != 5'd0) &&
                ((E_rd == D_ra) || (E_rd == D_rb));

    // A memory stall freezes the whole pipe, so it outranks every other hazard.
    always_comb begin
        pc_en      = 1'b1;
        F_D_en     = 1'b1;
        D_E_en     = 1'b1;
        E_M_en     = 1'b1;
        F_D_flush  = 1'b0;
        CTRL_Flush = 1'b0;
        E_M_flush  = 1'b0;
        M_W_flush  = 1'b0;
        mdiv_done  = 1'b0;
        if (!rst_n) begin
            pc_en  = 1'b0;
            F_D_en = 1'b0;
            D_E_en = 1'b0;
            E_M_en = 1'b0;
        end else if (mem_stall) begin
            pc_en     = 1'b0;
            F_D_en    = 1'b0;
            D_E_en    = 1'b0;
            E_M_en    = 1'b0;
            M_W_flush = 1'b1;
        end else if (mdiv_freeze) begin
            pc_en     = 1'b0;
            F_D_en    = 1'b0;
            D_E_en    = 1'b0;
            E_M_flush = 1'b1;
        end else if (E_redirect) begin
            F_D_flush  = 1'b1;
            CTRL_Flush = 1'b1;
            mdiv_done  = mdiv_release;
        end else if (lu) begin
            pc_en      = 1'b0;
            F_D_en     = 1'b0;
            CTRL_Flush = 1'b1;
            mdiv_done  = mdiv_release;
        end else begin
            mdiv_done  = mdiv_release;
        end
    end

    // mcnt counts the remaining freeze cycles; the whole FSM holds during memory stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_state <= EX_RUN;
            mcnt     <= '0;
        end else if (!mem_stall) begin
            case (ex_state)
                EX_RUN: begin
                    if (E_mdiv) begin
                        ex_state <= EX_MDIV;
                        mcnt     <= MCW'(MDIV_LAT - 2);
                    end
                end
                EX_MDIV: begin
                    if (mcnt != '0) mcnt <= mcnt - MCW'(1);
                    else            ex_state <= EX_RUN;
                end
                default: ex_state <= EX_RUN;
            endcase
        end
    end

    // A withdrawn request also ends the wait so a stale count cannot raise mem_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_state <= M_IDLE;
            wcnt      <= '0;
            mem_err   <= 1'b0;
        end else begin
            case (mem_state)
                M_IDLE: begin
                    if (M_mem_req && !mem_ready) begin
                        mem_state <= M_WAIT;
                        wcnt      <= WCW'(1);
                    end
                end
                M_WAIT: begin
                    if (timeout_now) begin
                        mem_state <= M_IDLE;
                        wcnt      <= '0;
                        mem_err   <= 1'b1;
                    end else if (mem_ready || !M_mem_req) begin
                        mem_state <= M_IDLE;
                        wcnt      <= '0;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                default: mem_state <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. Decides every cycle whether each pipeline register (F/PC, F_D, D_E, E_M, M_W) loads, holds or is bubbled, covering load-use hazards, taken branch/jump redirects, multi-cycle mul/div occupancy of Execute, and data-memory wait states with a timeout. Sits beside the datapath; its enables and flushes drive the stage registers directly, including the D_E register's `D_E_en` and `CTRL_Flush`.

## Interface
- `MDIV_LAT`, 4: total cycles a mul/div op occupies Execute; legal range is 2 or more.
- `MEM_TIMEOUT`, 16: maximum consecutive data-memory wait cycles before forced release.
- `CNT_WIDTH`, 32: width of the stall cycle counter.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `D_ra`, `D_rb`, in, 5 each: source registers of the instruction in Decode.
- `E_rd`, in, 5: destination register of the instruction in Execute.
- `E_RegWrite`, in, 1: the instruction in Execute writes the register file.
- `E_result_src`, in, 2: result source in Execute; `2'b01` = load.
- `E_redirect`, in, 1: a taken branch or jump in Execute redirects the PC.
- `E_mdiv`, in, 1: Execute holds a mul/div op.
- `M_mem_req`, in, 1: Memory stage is accessing data memory.
- `mem_ready`, in, 1: data memory completes the access this cycle.
- `pc_en`, `F_D_en`, `D_E_en`, `E_M_en`, out, 1 each: stage register load enables.
- `F_D_flush`, `CTRL_Flush`, `E_M_flush`, `M_W_flush`, out, 1 each: bubble insertion for F_D, D_E, E_M and M_W. `CTRL_Flush` is the D_E flush.
- `mdiv_done`, out, 1: 1-cycle pulse when the mul/div result is released.
- `mem_err`, out, 1: sticky memory-timeout flag.
- `stall_cnt`, out, `CNT_WIDTH`: count of cycles with `pc_en`=0, saturating.

## Operation
- **Two FSMs:**
  - EX FSM: `EX_RUN`, `EX_MDIV`, with down-counter `mcnt` of width clog2(`MDIV_LAT`).
  - MEM FSM: `M_IDLE`, `M_WAIT`, with counter `wcnt` of width clog2(`MEM_TIMEOUT`+1).
- **Condition signals:**
  - `mem_stall` = `M_mem_req` & !`mem_ready` & !`timeout_now`.
  - `timeout_now` = (`M_WAIT` & `wcnt`==`MEM_TIMEOUT`).
  - `mdiv_freeze` = (`EX_RUN` & `E_mdiv`) | (`EX_MDIV` & `mcnt`!=0).
  - `lu` = `E_RegWrite` & `E_result_src`==01 & `E_rd`!=0 & (`E_rd`==`D_ra` | `E_rd`==`D_rb`).
- **Default outputs:** all enables 1, all flushes 0.
- **Priority, highest first:**
  1. `mem_stall`: `pc_en`=`F_D_en`=`D_E_en`=`E_M_en`=0, `M_W_flush`=1. All other hazards are ignored.
  2. `mdiv_freeze`: `pc_en`=`F_D_en`=`D_E_en`=0, `E_M_flush`=1.
  3. `E_redirect`: `F_D_flush`=1, `CTRL_Flush`=1. Enables stay 1 so the PC loads the target.
  4. `lu`: `pc_en`=`F_D_en`=0, `CTRL_Flush`=1, giving a one-bubble stall.
- **EX FSM transitions:**
  - `EX_RUN` with `E_mdiv` and no `mem_stall`: load `mcnt`=`MDIV_LAT`-2, go to `EX_MDIV`.
  - `EX_MDIV` with `mcnt`!=0: decrement.
  - `EX_MDIV` with `mcnt`==0: release cycle. `mdiv_done`=1, enables on, go to `EX_RUN`.
  - Any `mem_stall` cycle: EX FSM and `mcnt` hold, and `mdiv_done` is suppressed.
  - A back-to-back mul/div is detected fresh in `EX_RUN` after release.
- **MEM FSM transitions:**
  - `M_IDLE` to `M_WAIT` on `M_mem_req` & !`mem_ready`, with `wcnt`=1.
  - In `M_WAIT`, `wcnt` increments each cycle.
  - Exit to `M_IDLE` on `mem_ready`, or on `timeout_now`.
  - On `timeout_now`, `mem_err` is set, and the stall is dropped that cycle (forced release).
  - `mem_err` clears only on reset.
- **`stall_cnt`:** increments on every cycle with `rst_n`=1 and `pc_en`=0; it holds at all-ones.

## Timing
- State, `mcnt`, `wcnt`, `mem_err` and `stall_cnt` update on the rising `clk` edge.
- All enables, flushes and `mdiv_done` are combinational from current state and inputs. They must settle within half a cycle, because the D_E register samples on the falling edge.
- **Reset** (`rst_n`=0, asynchronous):
  - State is `EX_RUN`/`M_IDLE`, and `mcnt`, `wcnt`, `mem_err`, `stall_cnt` are 0.
  - While reset is held, enables and flushes are forced to 0 and `mdiv_done` is 0.
  - Reset mid-mul/div or mid-wait abandons the op with no `mdiv_done` pulse.
- **Mul/div timing:** Execute occupancy is exactly `MDIV_LAT` cycles (`MDIV_LAT`-1 freeze cycles plus 1 release cycle), plus any `mem_stall` cycles.
- **Load-use:** exactly 1 stall cycle per hazard. The next cycle sees a bubble in Execute, so `lu` drops.
- **Redirect:** flushes take effect the same cycle as `E_redirect`. Redirect plus `lu` in the same cycle is handled as redirect only.

## Test plan
- **Load-use:** `E_RegWrite`=1, `E_result_src`=01, `E_rd`=5, `D_ra`=5 → for 1 cycle `pc_en`=0, `F_D_en`=0, `CTRL_Flush`=1, `D_E_en`=1, and `stall_cnt` +1. Repeating with `E_rd`=0 gives no stall.
- **Mul/div:** `MDIV_LAT`=4, `E_mdiv` held → `D_E_en`=0 and `E_M_flush`=1 for 3 cycles, then the 4th cycle has `mdiv_done`=1 and all enables 1. Back-to-back mul/div → two 4-cycle windows.
- **Mem stall during mul/div:** `mem_ready`=0 for 2 cycles during the `mcnt`==0 cycle → `E_M_en`=0 and `M_W_flush`=1. `mdiv_done` is delayed 2 cycles and still pulses exactly once.
- **Redirect with load-use:** `E_redirect`=1 with `lu` true → `F_D_flush`=`CTRL_Flush`=1 and `pc_en`=1, with no stall.
- **Memory timeout:** `MEM_TIMEOUT`=16, `mem_ready` stuck at 0 → freeze for 16 cycles. Release happens on the 17th cycle, `mem_err`=1 and stays 1 until `rst_n`=0.
- **Async reset mid-operation:** `rst_n` pulsed low mid-`EX_MDIV` → all outputs 0 immediately. After release, the FSMs are in `EX_RUN`/`M_IDLE` and `stall_cnt`=0.
